// File: rtl/ooo_pkg.sv
// Shared sizing constants for the out-of-order core.
// Used by the free list, ROB and map table.
package ooo_pkg;
   localparam int PR_W      = 6;
   localparam int ARCH_REGS = 32;
   localparam int NUM_PR    = 64;
   localparam int FL_DEPTH  = NUM_PR - ARCH_REGS;

   typedef logic [PR_W-1:0] pr_t;
endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free PR numbers.
// Allocates at head, retires at tail, recovery restores at head-1.
module free_list
   import ooo_pkg::*;
#(
   parameter int PR_W_P     = PR_W,
   parameter int DEPTH      = FL_DEPTH,
   parameter int FIRST_FREE = ARCH_REGS,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              isDispatch,
   input  logic              RegDest,
   input  logic              hazard_stall,
   input  logic              rob_full,
   output logic [PR_W_P-1:0] PR_new,
   output logic              fl_empty,
   input  logic              retire_reg,
   input  logic              rob_empty,
   input  logic              RegDest_retire,
   input  logic [PR_W_P-1:0] PR_old_RT,
   input  logic              recover,
   input  logic              RegDest_out,
   input  logic [PR_W_P-1:0] PR_new_flush,
   output logic [CNT_W-1:0]  free_cnt,
   output logic              fl_error
);

   logic [PR_W_P-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic empty, full;
   logic alloc, ret, unalloc;
   logic ret_ok, unalloc_ok;
   logic [PTR_W-1:0] head_m1;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign head_m1 = head_q - 1'b1;

   assign alloc = isDispatch & RegDest & ~empty
                & ~rob_full & ~recover & ~hazard_stall;

   assign ret = retire_reg & ~rob_empty & RegDest_retire
              & ~recover & ~hazard_stall;

   assign unalloc = recover & RegDest_out;

   // Pushes into a full list are dropped and flagged.
   assign ret_ok     = ret & ~full;
   assign unalloc_ok = unalloc & ~full;

   always_comb begin
      head_d = head_q + PTR_W'(alloc) - PTR_W'(unalloc_ok);
      tail_d = tail_q + PTR_W'(ret_ok);
      cnt_d  = cnt_q + CNT_W'(ret_ok) + CNT_W'(unalloc_ok)
             - CNT_W'(alloc);
      err_d  = err_q | ((ret | unalloc) & full) | (alloc & empty);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= PR_W_P'(FIRST_FREE + i);
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= CNT_W'(DEPTH);
         err_q  <= 1'b0;
      end else begin
         if (ret_ok)
            mem_q[tail_q] <= PR_old_RT;
         else if (unalloc_ok)
            mem_q[head_m1] <= PR_new_flush;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign PR_new   = mem_q[head_q];
   assign fl_empty = empty;
   assign free_cnt = cnt_q;
   assign fl_error = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_free_list;
   import ooo_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       isDispatch, RegDest, hazard_stall, rob_full;
   logic [5:0] PR_new;
   logic       fl_empty;
   logic       retire_reg, rob_empty, RegDest_retire;
   logic [5:0] PR_old_RT;
   logic       recover, RegDest_out;
   logic [5:0] PR_new_flush;
   logic [5:0] free_cnt;
   logic       fl_error;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   free_list dut (
      .clk            (clk),
      .rst            (rst),
      .isDispatch     (isDispatch),
      .RegDest        (RegDest),
      .hazard_stall   (hazard_stall),
      .rob_full       (rob_full),
      .PR_new         (PR_new),
      .fl_empty       (fl_empty),
      .retire_reg     (retire_reg),
      .rob_empty      (rob_empty),
      .RegDest_retire (RegDest_retire),
      .PR_old_RT      (PR_old_RT),
      .recover        (recover),
      .RegDest_out    (RegDest_out),
      .PR_new_flush   (PR_new_flush),
      .free_cnt       (free_cnt),
      .fl_error       (fl_error)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      isDispatch     = 1'b0;
      RegDest        = 1'b0;
      hazard_stall   = 1'b0;
      rob_full       = 1'b0;
      retire_reg     = 1'b0;
      rob_empty      = 1'b1;
      RegDest_retire = 1'b0;
      PR_old_RT      = '0;
      recover        = 1'b0;
      RegDest_out    = 1'b0;
      PR_new_flush   = '0;
   endtask

   task automatic set_ret(input logic en, input logic [5:0] pr);
      retire_reg     = en;
      rob_empty      = ~en;
      RegDest_retire = en;
      PR_old_RT      = pr;
   endtask

   task automatic set_alloc(input logic en);
      isDispatch = en;
      RegDest    = en;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      #3;
      chk("rst_pr_new", PR_new, 32);
      chk("rst_cnt", free_cnt, 32);
      chk("rst_empty", fl_empty, 0);
      chk("rst_err", fl_error, 0);
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      do_reset();

      // 32 allocs drain the list in reset order
      set_alloc(1'b1);
      for (int i = 0; i < 32; i++) begin
         chk("alloc_seq", PR_new, 32 + i);
         step();
      end
      chk("drain_empty", fl_empty, 1);
      chk("drain_cnt", free_cnt, 0);
      step();
      chk("over_cnt", free_cnt, 0);
      chk("over_pr", PR_new, 32);

      // retire into empty list, alloc still asserted
      set_ret(1'b1, 6'd5);
      step();
      set_ret(1'b0, 6'd0);
      set_alloc(1'b0);
      chk("ret_empty", fl_empty, 0);
      chk("ret_pr", PR_new, 5);
      chk("ret_cnt", free_cnt, 1);

      // fill to 10 with PRs 10..18
      for (int i = 0; i < 9; i++) begin
         set_ret(1'b1, 6'(10 + i));
         step();
      end
      chk("fill_cnt", free_cnt, 10);

      // simultaneous alloc and retire
      set_ret(1'b1, 6'd7);
      set_alloc(1'b1);
      chk("both_pr", PR_new, 5);
      step();
      set_ret(1'b0, 6'd0);
      chk("both_cnt", free_cnt, 10);
      for (int i = 0; i < 9; i++) begin
         chk("order_seq", PR_new, 10 + i);
         step();
      end
      chk("order_tail", PR_new, 7);
      step();
      chk("order_cnt", free_cnt, 0);
      set_alloc(1'b0);

      do_reset();

      // allocate 32,33,34 then walk them back
      set_alloc(1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("spec_alloc", PR_new, 32 + i);
         step();
      end
      chk("spec_cnt", free_cnt, 29);
      recover     = 1'b1;
      RegDest_out = 1'b1;
      for (int i = 0; i < 3; i++) begin
         PR_new_flush = 6'(34 - i);
         step();
         chk("rec_pr", PR_new, 34 - i);
         chk("rec_cnt", free_cnt, 30 + i);
      end
      chk("rec_done_pr", PR_new, 32);
      recover     = 1'b0;
      RegDest_out = 1'b0;

      // recover without RegDest_out, retire held high
      step();
      set_alloc(1'b0);
      chk("pre_cnt", free_cnt, 31);
      recover = 1'b1;
      set_ret(1'b1, 6'd9);
      step();
      chk("norec_cnt", free_cnt, 31);
      chk("norec_pr", PR_new, 33);
      chk("norec_err", fl_error, 0);
      set_ret(1'b0, 6'd0);
      RegDest_out  = 1'b1;
      PR_new_flush = 6'd32;
      step();
      recover     = 1'b0;
      RegDest_out = 1'b0;
      chk("refill_cnt", free_cnt, 32);
      chk("refill_pr", PR_new, 32);

      // retire into full list
      set_ret(1'b1, 6'd9);
      step();
      set_ret(1'b0, 6'd0);
      chk("full_cnt", free_cnt, 32);
      chk("full_pr", PR_new, 32);
      chk("full_err", fl_error, 1);
      step();
      chk("err_sticky", fl_error, 1);

      // reset in the middle of a recovery
      set_alloc(1'b1);
      step();
      step();
      set_alloc(1'b0);
      recover      = 1'b1;
      RegDest_out  = 1'b1;
      PR_new_flush = 6'd33;
      step();
      chk("midrec_cnt", free_cnt, 31);
      #1 rst = 1'b0;
      #1;
      chk("arst_cnt", free_cnt, 32);
      chk("arst_pr", PR_new, 32);
      chk("arst_err", fl_error, 0);
      chk("arst_empty", fl_empty, 0);
      step();
      idle();
      rst = 1'b1;
      set_alloc(1'b1);
      chk("post_pr0", PR_new, 32);
      step();
      chk("post_pr1", PR_new, 33);
      chk("post_cnt", free_cnt, 31);
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
